// File: rtl/valid_timer.sv
// ---------------------------------------------------------------------------
// valid_timer
//
// Purpose:
//   Generates the one-cycle advance pulse (o_valid) for a downstream LED shift
//   register. It supports two modes:
//   - Free-run: while i_enable is high, the counter runs. It pulses once every
//     LIMIT[i_sel]+1 cycles.
//   - Single-step: while i_enable is low, each rising edge of i_step produces
//     exactly one pulse.
//
// Ports:
//   clock      - single clock, all state updates on its rising edge
//   i_reset_n  - synchronous, active-low reset
//   i_enable   - free-run request (level)
//   i_sel      - period select, picks LIMIT_0..LIMIT_3
//   i_step     - single-step request (rising-edge sensitive)
//   o_valid    - registered one-cycle advance pulse
//   o_running  - registered, high exactly while the FSM is in RUN
//
// Parameters:
//   NB_COUNTER - counter width in bits
//   LIMIT_n    - terminal count for i_sel = n (must fit in NB_COUNTER bits)
// ---------------------------------------------------------------------------
module valid_timer #(
  parameter int NB_COUNTER = 32,
  parameter int LIMIT_0    = (2**23)-1,
  parameter int LIMIT_1    = (2**24)-1,
  parameter int LIMIT_2    = (2**25)-1,
  parameter int LIMIT_3    = (2**26)-1
) (
  input  logic       clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [1:0] i_sel,
  input  logic       i_step,
  output logic       o_valid,
  output logic       o_running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [NB_COUNTER-1:0] LIM_0 = NB_COUNTER'(LIMIT_0);
  localparam logic [NB_COUNTER-1:0] LIM_1 = NB_COUNTER'(LIMIT_1);
  localparam logic [NB_COUNTER-1:0] LIM_2 = NB_COUNTER'(LIMIT_2);
  localparam logic [NB_COUNTER-1:0] LIM_3 = NB_COUNTER'(LIMIT_3);

  state_t                state;
  logic [NB_COUNTER-1:0] counter;
  logic [NB_COUNTER-1:0] limit;
  logic                  step_prev;
  logic                  step_edge;
  logic                  terminal;

  // Select the active terminal count. The limit is compared against the
  // counter with >= rather than ==. If i_sel switches to a smaller limit
  // mid-count, the timer fires at once instead of wrapping through the full
  // counter range.
  //
  // A terminal count is held off while o_valid is already high. This only
  // matters when the limit is 0, because the counter sits at 0 right after
  // every pulse. In that case the timer takes one extra increment, so a zero
  // limit gives a pulse every second cycle and o_valid is never high twice in
  // a row.
  always_comb begin
    limit = LIM_0;
    case (i_sel)
      2'd0:    limit = LIM_0;
      2'd1:    limit = LIM_1;
      2'd2:    limit = LIM_2;
      default: limit = LIM_3;
    endcase
    step_edge = i_step & ~step_prev;
    terminal  = (counter >= limit) && !o_valid;
  end

  // Main FSM with registered outputs.
  //
  // step_prev resets to 1. As a result, an i_step held high through reset
  // release is not seen as an edge.
  //
  // Step edges are only acted on in IDLE, and only when i_enable is low.
  // Edges seen in any other case are dropped and not queued.
  //
  // When the FSM leaves RUN because i_enable falls, the counter holds its
  // value so that a later return to RUN resumes the count where it paused.
  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      o_valid   <= 1'b0;
      o_running <= 1'b0;
      step_prev <= 1'b1;
    end else begin
      step_prev <= i_step;
      o_valid   <= 1'b0;
      o_running <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) begin
            state     <= RUN;
            o_running <= 1'b1;
          end else if (step_edge) begin
            state   <= STEP;
            o_valid <= 1'b1;
          end
        end
        RUN: begin
          if (!i_enable) begin
            state <= IDLE;
          end else begin
            o_running <= 1'b1;
            if (terminal) begin
              counter <= '0;
              o_valid <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        STEP: begin
          state   <= IDLE;
          counter <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the outputs.
  a_no_double_valid: assert property (
    @(posedge clock) disable iff (!i_reset_n) o_valid |=> !o_valid
  );

  a_running_is_run: assert property (
    @(posedge clock) disable iff (!i_reset_n) o_running == (state == RUN)
  );

endmodule

// File: tb/tb_valid_timer.sv
// ---------------------------------------------------------------------------
// tb_valid_timer
//
// Purpose:
//   Self-checking bench for valid_timer. It uses small limits:
//   LIMIT_0=3, LIMIT_1=9, LIMIT_2=0, LIMIT_3=5.
//
//   The bench has two parts:
//   - A table of per-cycle vectors. Each vector holds the inputs and the
//     expected outputs after one rising edge.
//   - Hand-written sequences for the multi-cycle corner cases: separated
//     steps, a held step, and reset during a terminal count.
// ---------------------------------------------------------------------------
module tb_valid_timer;

  logic       clock = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_enable = 1'b0;
  logic [1:0] i_sel = 2'd0;
  logic       i_step = 1'b0;
  logic       o_valid;
  logic       o_running;

  int checks = 0;
  int errors = 0;

  valid_timer #(
    .NB_COUNTER(8),
    .LIMIT_0(3),
    .LIMIT_1(9),
    .LIMIT_2(0),
    .LIMIT_3(5)
  ) dut (
    .clock    (clock),
    .i_reset_n(i_reset_n),
    .i_enable (i_enable),
    .i_sel    (i_sel),
    .i_step   (i_step),
    .o_valid  (o_valid),
    .o_running(o_running)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic       step;
    logic       exp_valid;
    logic       exp_running;
  } vec_t;

  vec_t vecs[$];

  // Append a number of identical vectors to the table.
  task automatic addVec(input int n, input logic r, input logic e, input logic [1:0] s,
                        input logic st, input logic ev, input logic er);
    vec_t v;
    v.rst_n = r; v.en = e; v.sel = s; v.step = st;
    v.exp_valid = ev; v.exp_running = er;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Drive inputs, then let one rising edge pass and sample 1 ns after it.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] s,
                               input logic st);
    i_reset_n = r; i_enable = e; i_sel = s; i_step = st;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic er);
    checks++;
    if (o_valid !== ev || o_running !== er) begin
      errors++;
      $display("[TB] FAIL %s: o_valid=%b o_running=%b, required o_valid=%b o_running=%b",
               name, o_valid, o_running, ev, er);
    end
  endtask

  // Compare a pulse count gathered over a sequence.
  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d pulses, required %0d", name, got, want);
    end
  endtask

  int pulses;

  initial begin
    // ---------------- table: reset, free-run, sel changes, pause, steps -------
    addVec(1, 0, 0, 0, 0, 0, 0);  // reset state
    addVec(1, 1, 1, 0, 0, 0, 1);  // IDLE->RUN, counter 0
    addVec(3, 1, 1, 0, 0, 0, 1);  // 1,2,3
    addVec(1, 1, 1, 0, 0, 1, 1);  // terminal at 3
    addVec(3, 1, 1, 0, 0, 0, 1);
    addVec(1, 1, 1, 0, 0, 1, 1);  // period 4
    addVec(7, 1, 1, 1, 0, 0, 1);  // limit 9: counter 1..7
    addVec(1, 1, 1, 0, 0, 1, 1);  // switch to limit 3 at 7 -> fires
    addVec(3, 1, 1, 0, 0, 0, 1);
    addVec(1, 1, 1, 0, 0, 1, 1);  // then every 4
    addVec(1, 1, 1, 2, 0, 0, 1);  // limit 0, held off right after pulse
    addVec(1, 1, 1, 2, 0, 1, 1);
    addVec(1, 1, 1, 2, 0, 0, 1);
    addVec(1, 1, 1, 2, 0, 1, 1);  // every second cycle
    addVec(5, 1, 1, 3, 0, 0, 1);  // limit 5: 1..5
    addVec(1, 1, 1, 3, 0, 1, 1);  // period 6
    addVec(5, 1, 1, 1, 0, 0, 1);  // limit 9: 1..5
    addVec(3, 1, 0, 1, 0, 0, 0);  // pause, hold 5
    addVec(1, 1, 1, 1, 0, 0, 1);  // resume at 5
    addVec(4, 1, 1, 1, 0, 0, 1);  // 6..9
    addVec(1, 1, 1, 1, 0, 1, 1);  // fires from held value
    addVec(1, 1, 0, 1, 0, 0, 0);  // to IDLE
    addVec(1, 1, 0, 1, 1, 1, 0);  // step edge -> STEP pulse
    addVec(1, 1, 0, 1, 1, 0, 0);  // held: back to IDLE, no pulse
    addVec(1, 1, 0, 1, 0, 0, 0);
    addVec(1, 1, 0, 1, 1, 1, 0);
    addVec(1, 1, 0, 1, 0, 0, 0);
    addVec(1, 1, 0, 1, 1, 1, 0);
    addVec(1, 1, 0, 1, 0, 0, 0);
    addVec(1, 1, 1, 1, 1, 0, 1);  // step + enable in IDLE: RUN wins
    addVec(1, 1, 1, 1, 0, 0, 1);
    addVec(1, 1, 1, 1, 1, 0, 1);  // edge in RUN discarded
    addVec(2, 1, 0, 1, 1, 0, 0);  // not queued after leaving RUN

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].sel, vecs[i].step);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_running);
    end

    // ---------------- three separated step pulses ------------------------------
    pulses = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1, 0, 0, 1);
      if (o_valid) pulses++;
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1, 0, 0, 0);
        if (o_valid) pulses++;
      end
    end
    checkCount("three_steps", pulses, 3);

    // ---------------- step held high 10 cycles ----------------------------------
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 1);
      if (o_valid) pulses++;
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0);
      if (o_valid) pulses++;
    end
    checkCount("held_step", pulses, 1);

    // ---------------- reset in the terminal-count cycle -------------------------
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_again", 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("rst_run_entry", 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);  // counter 1..3
    checkOutput("rst_pre_term", 0, 1);
    applyStimulus(0, 1, 0, 1);  // reset wins over terminal count
    checkOutput("rst_suppress", 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1);  // step high through release
      checkOutput($sformatf("rst_step_held%0d", i), 0, 0);
    end
    applyStimulus(1, 1, 0, 1);
    checkOutput("rst_rerun", 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("rst_cnt_cleared_a", 0, 1);  // counter was reset: now 3
    applyStimulus(1, 1, 0, 0);
    checkOutput("rst_cnt_cleared_b", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
